// File: rtl/writeback_arbiter.sv
// Two-requester register-file writeback arbiter.
// Round-robin between ALU (A) and multdiv (B) with a registered one-cycle write port.
module writeback_arbiter (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        a_valid,
   input  logic [4:0]  a_rd,
   input  logic [31:0] a_data,
   output logic        a_ready,
   input  logic        b_valid,
   input  logic [4:0]  b_rd,
   input  logic [31:0] b_data,
   output logic        b_ready,
   output logic        ctrl_writeEnable,
   output logic [4:0]  ctrl_writeReg,
   output logic [31:0] data_writeReg,
   output logic [31:0] we_onehot,
   output logic [1:0]  last_grant
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      GRANT_A = 2'b01,
      GRANT_B = 2'b10
   } state_t;

   state_t      state;
   logic        b_turn;
   logic        xfer;
   logic [4:0]  sel_rd;
   logic [31:0] sel_data;

   // B only wins a conflict right after A was served
   always_comb begin
      b_turn   = (state == GRANT_A);
      a_ready  = reset && !stall && a_valid && !(b_valid && b_turn);
      b_ready  = reset && !stall && b_valid && !(a_valid && !b_turn);
      xfer     = a_ready || b_ready;
      sel_rd   = a_ready ? a_rd : b_rd;
      sel_data = a_ready ? a_data : b_data;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state            <= IDLE;
         ctrl_writeEnable <= 1'b0;
         ctrl_writeReg    <= 5'd0;
         data_writeReg    <= 32'd0;
         we_onehot        <= 32'd0;
      end else begin
         ctrl_writeEnable <= xfer && (sel_rd != 5'd0);
         we_onehot        <= 32'd0;
         if (a_ready)
            state <= GRANT_A;
         else if (b_ready)
            state <= GRANT_B;
         // x0 writes are consumed but leave the write port untouched
         if (xfer && (sel_rd != 5'd0)) begin
            ctrl_writeReg <= sel_rd;
            data_writeReg <= sel_data;
            we_onehot     <= 32'd1 << sel_rd;
         end
      end
   end

   assign last_grant = state;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter.
// Directed scenarios followed by randomized traffic against a cycle model.
module tb_writeback_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        stall;
   logic        a_valid;
   logic [4:0]  a_rd;
   logic [31:0] a_data;
   logic        a_ready;
   logic        b_valid;
   logic [4:0]  b_rd;
   logic [31:0] b_data;
   logic        b_ready;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic [31:0] we_onehot;
   logic [1:0]  last_grant;

   writeback_arbiter dut (
      .clock            (clock),
      .reset            (reset),
      .stall            (stall),
      .a_valid          (a_valid),
      .a_rd             (a_rd),
      .a_data           (a_data),
      .a_ready          (a_ready),
      .b_valid          (b_valid),
      .b_rd             (b_rd),
      .b_data           (b_data),
      .b_ready          (b_ready),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .data_writeReg    (data_writeReg),
      .we_onehot        (we_onehot),
      .last_grant       (last_grant)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        ar;
      logic        br;
      logic        we;
      logic [4:0]  wr;
      logic [31:0] wd;
      logic [31:0] oh;
      logic [1:0]  lg;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   active   = 0;

   // Reference: who was served last (0 none, 1 A, 2 B) and the last real write
   int          m_last = 0;
   logic        m_we   = 0;
   logic [4:0]  m_reg  = 0;
   logic [31:0] m_data = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle(input logic r, input logic s,
                        input logic av, input logic [4:0] ar,
                        input logic [31:0] ad,
                        input logic bv, input logic [4:0] br,
                        input logic [31:0] bd,
                        output logic ga, output logic gb);
      exp_t e;
      int   win;
      @(posedge clock);
      #1;
      reset = r; stall = s;
      a_valid = av; a_rd = ar; a_data = ad;
      b_valid = bv; b_rd = br; b_data = bd;
      win = 0;
      if (r && !s) begin
         if (av && bv) win = (m_last == 1) ? 2 : 1;
         else if (av)  win = 1;
         else if (bv)  win = 2;
      end
      e.ar = (win == 1);
      e.br = (win == 2);
      e.we = m_we;
      e.wr = m_reg;
      e.wd = m_data;
      e.oh = '0;
      if (m_we) e.oh[m_reg] = 1'b1;
      e.lg = 2'(m_last);
      sb.push_back(e);
      ga = (win == 1);
      gb = (win == 2);
      if (!r) begin
         m_last = 0; m_we = 0; m_reg = 0; m_data = 0;
      end else begin
         m_we = 0;
         if (win != 0) begin
            m_last = win;
            if ((win == 1 ? ar : br) != 5'd0) begin
               m_we   = 1;
               m_reg  = (win == 1) ? ar : br;
               m_data = (win == 1) ? ad : bd;
            end
         end
      end
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("a_ready", 32'(a_ready), 32'(e.ar));
         check("b_ready", 32'(b_ready), 32'(e.br));
         check("writeEnable", 32'(ctrl_writeEnable), 32'(e.we));
         check("writeReg", 32'(ctrl_writeReg), 32'(e.wr));
         check("writeData", data_writeReg, e.wd);
         check("we_onehot", we_onehot, e.oh);
         check("last_grant", 32'(last_grant), 32'(e.lg));
      end
      if (active) begin
         check("ready_excl", 32'(a_ready && b_ready), 32'd0);
         if (ctrl_writeEnable === 1'b1)
            check("onehot_bits", 32'($countones(we_onehot)), 32'd1);
      end
   end

   initial begin
      logic        ga, gb;
      logic        pa, pb;
      logic        av, bv, r, s;
      logic [4:0]  ar, br;
      logic [31:0] ad, bd;
      int          wait_n;

      reset = 0; stall = 0;
      a_valid = 0; a_rd = 0; a_data = 0;
      b_valid = 0; b_rd = 0; b_data = 0;
      @(posedge clock);
      @(posedge clock);
      active = 1;

      // reset state observed while still in reset
      cycle(0, 0, 0, 0, 0, 0, 0, 0, ga, gb);
      // single write
      cycle(1, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, ga, gb);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, ga, gb);
      // conflict from IDLE
      cycle(0, 0, 0, 0, 0, 0, 0, 0, ga, gb);
      for (int i = 0; i < 4; i++)
         cycle(1, 0, 1, 3, 32'hA0A0_0003, 1, 7, 32'hB0B0_0007, ga, gb);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, ga, gb);
      // rd = 0 accepted but not written
      cycle(1, 0, 0, 0, 0, 1, 0, 32'h1234, ga, gb);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, ga, gb);
      // stall after a grant to A
      cycle(1, 0, 1, 4, 32'h4444, 0, 0, 0, ga, gb);
      for (int i = 0; i < 3; i++)
         cycle(1, 1, 1, 6, 32'h6666, 1, 8, 32'h8888, ga, gb);
      cycle(1, 0, 1, 6, 32'h6666, 1, 8, 32'h8888, ga, gb);
      cycle(1, 0, 1, 6, 32'h6666, 0, 0, 0, ga, gb);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, ga, gb);
      // reset mid-transfer
      cycle(0, 0, 1, 9, 32'h9999, 0, 0, 0, ga, gb);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, ga, gb);
      // decode sweep
      for (int i = 1; i < 32; i++)
         cycle(1, 0, 1, 5'(i), 32'h1000 + 32'(i), 0, 0, 0, ga, gb);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, ga, gb);

      // random traffic; a pending request is held until granted
      pa = 0; pb = 0;
      av = 0; bv = 0; ar = 0; br = 0; ad = 0; bd = 0;
      for (int i = 0; i < 400; i++) begin
         if (!pa) begin
            av = ($urandom_range(0, 9) < 6);
            ar = 5'($urandom_range(0, 31));
            ad = $urandom;
         end
         if (!pb) begin
            bv = ($urandom_range(0, 9) < 6);
            br = 5'($urandom_range(0, 31));
            bd = $urandom;
         end
         r = ($urandom_range(0, 49) != 0);
         s = ($urandom_range(0, 9) < 2);
         cycle(r, s, av, ar, ad, bv, br, bd, ga, gb);
         pa = av && !ga;
         pb = bv && !gb;
      end
      cycle(1, 0, 0, 0, 0, 0, 0, 0, ga, gb);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, ga, gb);

      wait_n = 0;
      while (sb.size() > 0 && wait_n < 20) begin
         @(posedge clock);
         wait_n++;
      end
      @(posedge clock);
      if (sb.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d records left, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
